led_status_scheduler: RTL and testbench

Shares the single front-panel status LED among four status sources and shows each as a blink code. The sources are heartbeat/data activity, UART upload, 50Hz sync loss and latched fault. The block owns a 50Hz sync watchdog and a fault latch, and runs a non-preemptive priority scheduler. It sits beside the LED board drivers and is fed by the same sync, data-update and UART strobes.

---
 rtl/led_status_scheduler.sv | 173 +++++++++++++++++
 tb/tb_led_status_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_status_scheduler.sv
// Front-panel status LED scheduler: shares one LED among heartbeat, UART upload,
// 50Hz sync loss and latched fault, each shown as a non-preemptive blink code.
module led_status_scheduler #(
    parameter int CLK_PER_MS      = 50000,
    parameter int SYNC_WIN_MS     = 1000,
    parameter int SYNC_MIN_PULSES = 45,
    parameter int BLINK_ON_MS     = 200,
    parameter int BLINK_OFF_MS    = 200,
    parameter int GAP_MS          = 1000
) (
    input  logic       iClk,
    input  logic       iRst_N,
    input  logic       iSync50Hz,
    input  logic       iNewDataUpdate,
    input  logic       iUARTUploading,
    input  logic       iFaultReq,
    input  logic [2:0] iFaultCode,
    input  logic       iFaultClr,
    output logic       oLED,
    output logic       oSyncLost,
    output logic [2:0] oFaultLatched,
    output logic [1:0] oActiveSrc,
    output logic       oBusy
);

    localparam int ON_CYC  = BLINK_ON_MS * CLK_PER_MS;
    localparam int OFF_CYC = BLINK_OFF_MS * CLK_PER_MS;
    localparam int GAP_CYC = GAP_MS * CLK_PER_MS;
    localparam int MS_W    = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int WIN_W   = (SYNC_WIN_MS > 1) ? $clog2(SYNC_WIN_MS) : 1;

    localparam logic [1:0] SRC_HB    = 2'd0;
    localparam logic [1:0] SRC_UART  = 2'd1;
    localparam logic [1:0] SRC_SYNC  = 2'd2;
    localparam logic [1:0] SRC_FAULT = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_GAP} stateT;

    stateT            state;
    logic [31:0]      phase;
    logic [2:0]       blinksLeft;
    logic             dataSeen;
    logic [MS_W-1:0]  msCnt;
    logic             msTick;
    logic [WIN_W-1:0] winCnt;
    logic [7:0]       pulseCnt;
    logic             winClose;
    logic [1:0]       grantSrc;
    logic [2:0]       grantN;

    assign msTick   = (msCnt == MS_W'(CLK_PER_MS - 1));
    assign winClose = msTick && (winCnt == WIN_W'(SYNC_WIN_MS - 1));

    // NOTE: registers use non-blocking assignments so every always_ff reads pre-edge values.
    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            msCnt <= '0;
        end else if (msTick) begin
            msCnt <= '0;
        end else begin
            msCnt <= msCnt + 1'b1;
        end
    end

    // A pulse landing on the window-closing edge is the first pulse of the new window.
    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            winCnt    <= '0;
            pulseCnt  <= '0;
            oSyncLost <= 1'b0;
        end else if (winClose) begin
            winCnt    <= '0;
            oSyncLost <= (pulseCnt < 8'(SYNC_MIN_PULSES));
            pulseCnt  <= iSync50Hz ? 8'd1 : 8'd0;
        end else begin
            if (msTick) winCnt <= winCnt + 1'b1;
            if (iSync50Hz && pulseCnt != 8'hFF) pulseCnt <= pulseCnt + 8'd1;
        end
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            oFaultLatched <= '0;
        end else if (iFaultReq && iFaultCode != 3'd0) begin
            oFaultLatched <= iFaultCode;
        end else if (iFaultClr) begin
            oFaultLatched <= '0;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned and infers a latch.
        grantSrc = SRC_HB;
        grantN   = {2'b00, dataSeen};
        if (oFaultLatched != 3'd0) begin
            grantSrc = SRC_FAULT;
            grantN   = oFaultLatched;
        end else if (oSyncLost) begin
            grantSrc = SRC_SYNC;
            grantN   = 3'd3;
        end else if (iUARTUploading) begin
            grantSrc = SRC_UART;
            grantN   = 3'd2;
        end
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            state      <= ST_IDLE;
            phase      <= '0;
            blinksLeft <= '0;
            dataSeen   <= 1'b0;
            oActiveSrc <= '0;
            oLED       <= 1'b0;
            oBusy      <= 1'b0;
        end else begin
            if (iNewDataUpdate) dataSeen <= 1'b1;
            case (state)
                ST_IDLE: begin
                    oActiveSrc <= grantSrc;
                    blinksLeft <= grantN;
                    phase      <= '0;
                    oBusy      <= 1'b1;
                    if (grantSrc == SRC_HB && !iNewDataUpdate) dataSeen <= 1'b0;
                    if (grantN == 3'd0) begin
                        state <= ST_GAP;
                    end else begin
                        state <= ST_ON;
                        oLED  <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (phase == 32'(ON_CYC - 1)) begin
                        phase <= '0;
                        state <= ST_OFF;
                        oLED  <= 1'b0;
                    end else begin
                        phase <= phase + 32'd1;
                    end
                end
                ST_OFF: begin
                    if (phase == 32'(OFF_CYC - 1)) begin
                        phase      <= '0;
                        blinksLeft <= blinksLeft - 3'd1;
                        if (blinksLeft != 3'd1) begin
                            state <= ST_ON;
                            oLED  <= 1'b1;
                        end else begin
                            state <= ST_GAP;
                        end
                    end else begin
                        phase <= phase + 32'd1;
                    end
                end
                ST_GAP: begin
                    if (phase == 32'(GAP_CYC - 1)) begin
                        phase <= '0;
                        state <= ST_IDLE;
                        oBusy <= 1'b0;
                    end else begin
                        phase <= phase + 32'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    oLED  <= 1'b0;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_status_scheduler.sv
// Scoreboard bench for led_status_scheduler: stimulus queues expected blink
// sequences, a monitor measures each sequence on the LED and compares.
module tb_led_status_scheduler;

    localparam int CPM          = 10;
    localparam int WIN_MS       = 20;
    localparam int MIN_PULSES   = 3;
    localparam int ON_MS        = 2;
    localparam int OFF_MS       = 2;
    localparam int GAP_MS       = 5;
    localparam int ON_CYC       = ON_MS * CPM;
    localparam int BLINK_PERIOD = (ON_MS + OFF_MS) * CPM;
    localparam int GAP_CYC      = GAP_MS * CPM;

    logic       iClk = 1'b0;
    logic       iRst_N;
    logic       iSync50Hz;
    logic       iNewDataUpdate;
    logic       iUARTUploading;
    logic       iFaultReq;
    logic [2:0] iFaultCode;
    logic       iFaultClr;
    logic       oLED;
    logic       oSyncLost;
    logic [2:0] oFaultLatched;
    logic [1:0] oActiveSrc;
    logic       oBusy;

    typedef struct {
        logic [1:0] src;
        int         n;
    } expT;

    expT expQ[$];
    int  syncAt[$];
    bit  syncEn;
    int  cyc;
    int  nChecks     = 0;
    int  nErrors     = 0;
    int  nSeqPushed  = 0;
    int  nSeqChecked = 0;

    led_status_scheduler #(
        .CLK_PER_MS(CPM), .SYNC_WIN_MS(WIN_MS), .SYNC_MIN_PULSES(MIN_PULSES),
        .BLINK_ON_MS(ON_MS), .BLINK_OFF_MS(OFF_MS), .GAP_MS(GAP_MS)
    ) dut (
        .iClk(iClk), .iRst_N(iRst_N), .iSync50Hz(iSync50Hz),
        .iNewDataUpdate(iNewDataUpdate), .iUARTUploading(iUARTUploading),
        .iFaultReq(iFaultReq), .iFaultCode(iFaultCode), .iFaultClr(iFaultClr),
        .oLED(oLED), .oSyncLost(oSyncLost), .oFaultLatched(oFaultLatched),
        .oActiveSrc(oActiveSrc), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nErrors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Sync strobe source: periodic mode or an explicit list of launch cycles.
    initial begin : syncGen
        iSync50Hz = 1'b0;
        forever begin
            @(negedge iClk);
            while (syncAt.size() > 0 && syncAt[0] < cyc) void'(syncAt.pop_front());
            if (iRst_N && syncAt.size() > 0 && syncAt[0] == cyc) begin
                void'(syncAt.pop_front());
                iSync50Hz = 1'b1;
            end else begin
                iSync50Hz = iRst_N && syncEn && (cyc % 50 == 25);
            end
        end
    end

    initial begin : monitor
        bit         inSeq;
        bit         prevLed;
        bit         haveExp;
        int         seqLen;
        int         blinks;
        int         badRuns;
        int         onRun;
        logic [1:0] src;
        expT        cur;
        inSeq = 0; prevLed = 0; haveExp = 0;
        seqLen = 0; blinks = 0; badRuns = 0; onRun = 0; src = '0;
        forever begin
            @(negedge iClk);
            if (!iRst_N) begin
                inSeq = 0; haveExp = 0; prevLed = 0;
            end else begin
                if (!inSeq && oBusy) begin
                    inSeq = 1; seqLen = 0; blinks = 0; badRuns = 0; onRun = 0;
                    src = oActiveSrc;
                    haveExp = (expQ.size() > 0);
                    if (haveExp) cur = expQ.pop_front();
                end
                if (inSeq && oBusy) begin
                    if (oLED) begin
                        if (!prevLed) begin
                            if (seqLen != blinks * BLINK_PERIOD) badRuns++;
                            blinks++;
                            onRun = 0;
                        end
                        onRun++;
                    end else if (prevLed && onRun != ON_CYC) begin
                        badRuns++;
                    end
                    seqLen++;
                end else if (inSeq && !oBusy) begin
                    if (prevLed || oLED) badRuns++;
                    inSeq = 0;
                    if (haveExp) begin
                        nSeqChecked++;
                        check("seqSrc", int'(src), int'(cur.src));
                        check("seqBlinks", blinks, cur.n);
                        check("seqLength", seqLen, cur.n * BLINK_PERIOD + GAP_CYC);
                        check("seqBadTiming", badRuns, 0);
                    end
                    haveExp = 0;
                end
                prevLed = oLED;
            end
        end
    end

    task automatic pushExp(input logic [1:0] s, input int n);
        expT e;
        e.src = s;
        e.n   = n;
        expQ.push_back(e);
        nSeqPushed++;
    endtask

    task automatic doReset(input bit uart, input bit doPush, input logic [1:0] s, input int n);
        iRst_N = 1'b0;
        iNewDataUpdate = 1'b0; iFaultReq = 1'b0; iFaultCode = '0; iFaultClr = 1'b0;
        iUARTUploading = uart;
        syncEn = 1'b0;
        syncAt.delete();
        repeat (3) @(negedge iClk);
        check("rstLed", oLED, 0);
        check("rstBusy", oBusy, 0);
        check("rstSyncLost", oSyncLost, 0);
        check("rstFault", oFaultLatched, 0);
        check("rstSrc", oActiveSrc, 0);
        expQ.delete();
        if (doPush) pushExp(s, n);
        iRst_N = 1'b1;
    endtask

    task automatic waitCyc(input int c);
        while (cyc < c) @(negedge iClk);
    endtask

    task automatic waitIdle();
        int budget = 0;
        @(negedge iClk);
        while (oBusy && budget < 1000) begin
            @(negedge iClk);
            budget++;
        end
        check("idleReached", oBusy ? 0 : 1, 1);
    endtask

    task automatic pulseData();
        iNewDataUpdate = 1'b1;
        @(negedge iClk);
        iNewDataUpdate = 1'b0;
    endtask

    task automatic faultStrobe(input bit req, input logic [2:0] code, input bit clr);
        iFaultReq = req; iFaultCode = code; iFaultClr = clr;
        @(negedge iClk);
        iFaultReq = 1'b0; iFaultCode = '0; iFaultClr = 1'b0;
    endtask

    initial begin : globalTimeout
        #500000;
        $display("FAIL globalTimeout: got running, expected finished");
        $fatal(1, "bench stalled");
    end

    initial begin : stimulus
        iRst_N = 1'b0;
        iNewDataUpdate = 1'b0; iUARTUploading = 1'b0;
        iFaultReq = 1'b0; iFaultCode = '0; iFaultClr = 1'b0;
        syncEn = 1'b0;
        @(negedge iClk);

        // 1: idle heartbeat, then sync loss after the first empty window
        doReset(1'b0, 1'b1, 2'd0, 0);
        waitCyc(199);
        check("syncLostBeforeClose", oSyncLost, 0);
        waitCyc(200);
        check("syncLostAtClose", oSyncLost, 1);
        waitIdle();
        pushExp(2'd2, 3);
        waitIdle();

        // 2: healthy sync plus one data frame
        doReset(1'b0, 1'b1, 2'd0, 0);
        syncEn = 1'b1;
        waitCyc(10);
        pulseData();
        waitIdle();
        pushExp(2'd0, 1);
        waitIdle();
        pushExp(2'd0, 0);
        waitIdle();
        waitCyc(205);
        check("syncOkWin1", oSyncLost, 0);
        waitCyc(405);
        check("syncOkWin2", oSyncLost, 0);

        // 2b: pulse coincident with window close belongs to the next window
        doReset(1'b0, 1'b0, 2'd0, 0);
        syncAt = '{50, 100, 199, 250, 300};
        waitCyc(200);
        check("syncShortWindow", oSyncLost, 1);
        waitCyc(400);
        check("syncExactMinimum", oSyncLost, 0);

        // 3: fault code 5, then clear mid-sequence
        doReset(1'b0, 1'b1, 2'd0, 0);
        waitCyc(10);
        faultStrobe(1'b1, 3'd5, 1'b0);
        check("faultLoad5", oFaultLatched, 5);
        waitIdle();
        pushExp(2'd3, 5);
        waitCyc(100);
        faultStrobe(1'b0, 3'd0, 1'b1);
        check("faultCleared", oFaultLatched, 0);
        waitIdle();
        pushExp(2'd2, 3);
        waitIdle();

        // 4: UART sequence is not preempted by a fault
        doReset(1'b1, 1'b1, 2'd1, 2);
        waitCyc(30);
        faultStrobe(1'b1, 3'd2, 1'b0);
        check("faultMidUart", oFaultLatched, 2);
        check("srcHeldUart", oActiveSrc, 1);
        waitIdle();
        pushExp(2'd3, 2);
        iUARTUploading = 1'b0;
        waitIdle();

        // 5: request beats clear; code 0 ignored; overwrite; clear
        doReset(1'b0, 1'b0, 2'd0, 0);
        waitCyc(10);
        faultStrobe(1'b1, 3'd3, 1'b1);
        check("faultReqBeatsClr", oFaultLatched, 3);
        waitCyc(20);
        faultStrobe(1'b1, 3'd0, 1'b0);
        check("faultCode0Ignored", oFaultLatched, 3);
        waitCyc(30);
        faultStrobe(1'b1, 3'd6, 1'b0);
        check("faultOverwrite", oFaultLatched, 6);
        waitCyc(40);
        faultStrobe(1'b0, 3'd0, 1'b1);
        check("faultClearOnly", oFaultLatched, 0);

        // 6: asynchronous reset during ON, then scenario 1 again
        doReset(1'b1, 1'b0, 2'd0, 0);
        waitCyc(5);
        check("ledOnBeforeReset", oLED, 1);
        #1 iRst_N = 1'b0;
        #1;
        check("ledAsyncDrop", oLED, 0);
        check("busyAsyncDrop", oBusy, 0);
        doReset(1'b0, 1'b1, 2'd0, 0);
        waitCyc(200);
        check("syncLostAfterRst", oSyncLost, 1);
        waitIdle();
        pushExp(2'd2, 3);
        waitIdle();

        check("allSeqsSeen", nSeqChecked, nSeqPushed);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
